// File: rtl/aoc_pkg.sv
// Shared definitions for the digit selection engine: one-hot state encoding,
// the width helper and the BCD digit limit.
package aoc_pkg;

  localparam int unsigned BCD_MAX = 9;

  localparam int unsigned ST_W = 5;
  localparam logic [ST_W-1:0] ST_IDLE  = 5'b00001;
  localparam logic [ST_W-1:0] ST_LOAD  = 5'b00010;
  localparam logic [ST_W-1:0] ST_SCAN  = 5'b00100;
  localparam logic [ST_W-1:0] ST_ACCUM = 5'b01000;
  localparam logic [ST_W-1:0] ST_DONE  = 5'b10000;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_SCAN  = ST_SCAN,
    S_ACCUM = ST_ACCUM,
    S_DONE  = ST_DONE
  } state_t;

  // Bits needed to index v entries; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = 1; x < v; x = x << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/digit_line_buf.sv
// Line storage: MAX_LEN x 4-bit register file, synchronous write, combinational read.
module digit_line_buf
  import aoc_pkg::*;
#(
  parameter int unsigned MAX_LEN = 128,
  parameter int unsigned AW      = clog2(MAX_LEN)
) (
  input  logic          sysclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rdata
);

  logic [3:0] mem [MAX_LEN];

  always_ff @(posedge sysclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/digit_select_engine.sv
// Greedy largest-K-digit subsequence per line, summed over a job of lines.
// Optional macro DIGIT_SEL_EARLY9_EN ends a scan window as soon as a 9 is found.
module digit_select_engine
  import aoc_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 128,
  parameter int unsigned MAX_K     = 16,
  parameter int unsigned MAX_LINES = 4096,
  parameter int unsigned ACC_W     = 64
) (
  input  logic                            sysclk,
  input  logic                            reset,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [clog2(MAX_K+1)-1:0]       cfg_k,
  input  logic [clog2(MAX_LINES+1)-1:0]   cfg_lines,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [3:0]                      in_digit,
  input  logic                            in_last,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [ACC_W-1:0]                res_sum,
  output logic                            res_ovf,
  output logic                            err,
  output logic                            busy
);

  localparam int unsigned KW  = clog2(MAX_K + 1);
  localparam int unsigned LNW = clog2(MAX_LINES + 1);
  localparam int unsigned AW  = clog2(MAX_LEN);
  localparam int unsigned LW  = clog2(MAX_LEN + 1);

  state_t            state;
  logic [KW-1:0]     k_r, j;
  logic [LNW-1:0]    lines_left;
  logic [LW-1:0]     len, p, lo, hi, max_pos;
  logic [3:0]        max_d;
  logic [ACC_W-1:0]  line_v;

  logic              in_fire, buf_we, better, win_end;
  logic [3:0]        rd_digit, cur_max;
  logic [LW-1:0]     cur_pos, len_nxt;
  logic [ACC_W-1:0]  line_x10, line_nxt;
  logic [ACC_W:0]    sum_ext;

  assign cfg_ready = (state == S_IDLE) & ~reset;
  assign in_fire   = (state == S_LOAD) & in_valid & in_ready;
  assign buf_we    = in_fire & (len < LW'(MAX_LEN));
  assign len_nxt   = (len < LW'(MAX_LEN)) ? len + LW'(1) : len;

  digit_line_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .sysclk (sysclk),
    .we     (buf_we),
    .waddr  (AW'(len)),
    .wdata  ((in_digit > 4'(BCD_MAX)) ? 4'd0 : in_digit),
    .raddr  (AW'(p)),
    .rdata  (rd_digit)
  );

  // Strict compare keeps the earliest maximum; the first window slot always seeds it.
  assign better  = (p == lo) || (rd_digit > max_d);
  assign cur_max = better ? rd_digit : max_d;
  assign cur_pos = better ? p : max_pos;

`ifdef DIGIT_SEL_EARLY9_EN
  assign win_end = (p == hi) || (cur_max == 4'(BCD_MAX));
`else
  assign win_end = (p == hi);
`endif

  assign line_x10 = (line_v << 3) + (line_v << 1);
  assign line_nxt = line_x10 + ACC_W'(cur_max);
  assign sum_ext  = {1'b0, res_sum} + {1'b0, line_v};

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_ovf    <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      k_r        <= '0;
      j          <= '0;
      lines_left <= '0;
      len        <= '0;
      p          <= '0;
      lo         <= '0;
      hi         <= '0;
      max_pos    <= '0;
      max_d      <= '0;
      line_v     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            k_r        <= cfg_k;
            lines_left <= cfg_lines;
            res_sum    <= '0;
            res_ovf    <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b1;
            len        <= '0;
            line_v     <= '0;
            if (cfg_lines == '0) begin
              state     <= S_DONE;
              res_valid <= 1'b1;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (in_fire) begin
            len <= len_nxt;
            if ((in_digit > 4'(BCD_MAX)) || (len == LW'(MAX_LEN))) err <= 1'b1;
            if (in_last) begin
              in_ready <= 1'b0;
              if (32'(len_nxt) < 32'(k_r)) err <= 1'b1;
              if ((k_r == '0) || (32'(len_nxt) < 32'(k_r))) begin
                line_v <= '0;
                state  <= S_ACCUM;
              end else begin
                state <= S_SCAN;
                j     <= '0;
                p     <= '0;
                lo    <= '0;
                hi    <= len_nxt - LW'(k_r);
              end
            end
          end
        end

        S_SCAN: begin
          max_d   <= cur_max;
          max_pos <= cur_pos;
          if (win_end) begin
            line_v <= line_nxt;
            if (j == k_r - KW'(1)) begin
              state <= S_ACCUM;
            end else begin
              j  <= j + KW'(1);
              lo <= cur_pos + LW'(1);
              p  <= cur_pos + LW'(1);
              hi <= hi + LW'(1);
            end
          end else begin
            p <= p + LW'(1);
          end
        end

        S_ACCUM: begin
          res_sum    <= sum_ext[ACC_W-1:0];
          if (sum_ext[ACC_W]) res_ovf <= 1'b1;
          line_v     <= '0;
          len        <= '0;
          lo         <= '0;
          lines_left <= lines_left - LNW'(1);
          if (lines_left == LNW'(1)) begin
            state     <= S_DONE;
            res_valid <= 1'b1;
          end else begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
          end
        end

        S_DONE: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_select_engine.sv
// Directed bench for digit_select_engine; a second 8-bit instance covers wraparound.
module tb_digit_select_engine;
  import aoc_pkg::*;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [4:0]  cfg_k;
  logic [12:0] cfg_lines;
  logic        in_valid;
  logic [3:0]  in_digit;
  logic        in_last;
  logic        res_ready;

  logic        cfg_ready, in_ready, res_valid, res_ovf, err, busy;
  logic [63:0] res_sum;
  logic        cfg_ready8, in_ready8, res_valid8, res_ovf8, err8, busy8;
  logic [7:0]  res_sum8;

  int tests = 0;
  int fails = 0;

  always #5 sysclk = ~sysclk;

  digit_select_engine dut (
    .sysclk(sysclk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_k(cfg_k), .cfg_lines(cfg_lines),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_ovf(res_ovf), .err(err), .busy(busy)
  );

  digit_select_engine #(.ACC_W(8)) dut8 (
    .sysclk(sysclk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready8), .cfg_k(cfg_k), .cfg_lines(cfg_lines),
    .in_valid(in_valid), .in_ready(in_ready8), .in_digit(in_digit), .in_last(in_last),
    .res_valid(res_valid8), .res_ready(res_ready), .res_sum(res_sum8),
    .res_ovf(res_ovf8), .err(err8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_job(input int k, input int n);
    int t = 0;
    cfg_valid = 1'b1;
    cfg_k     = 5'(k);
    cfg_lines = 13'(n);
    while (!cfg_ready && t < 100) begin @(negedge sysclk); t++; end
    if (!cfg_ready) check("cfg_timeout", 64'(cfg_ready), 64'd1);
    @(negedge sysclk);
    cfg_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_digit = d;
    in_last  = l;
    while (!in_ready && t < 1000) begin @(negedge sysclk); t++; end
    if (!in_ready) check("in_timeout", 64'(in_ready), 64'd1);
    @(negedge sysclk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++)
      push(4'(s[i] - 8'h30), (i == s.len() - 1));
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!res_valid && t < 5000) begin @(negedge sysclk); t++; end
    check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge sysclk);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    int n;

    reset = 1'b1; cfg_valid = 1'b0; cfg_k = '0; cfg_lines = '0;
    in_valid = 1'b0; in_digit = '0; in_last = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge sysclk);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_sum", res_sum, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    reset = 1'b0;
    @(negedge sysclk);
    check("idle_cfg_ready", 64'(cfg_ready), 64'd1);

    // Example set, k=2, with result backpressure
    start_job(2, 4);
    send_line("987654321111111");
    send_line("811111111111119");
    send_line("234234234234278");
    send_line("818181911112111");
    wait_done("k2");
    check("k2_sum", res_sum, 64'd357);
    check("k2_err", 64'(err), 64'd0);
    check("k2_ovf", 64'(res_ovf), 64'd0);
    held = res_sum;
    for (int i = 0; i < 5; i++) begin
      @(negedge sysclk);
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_sum", res_sum, held);
    end
    handshake();
    check("hs_valid_drop", 64'(res_valid), 64'd0);
    check("hs_idle", 64'(cfg_ready), 64'd1);
    check("hs_busy", 64'(busy), 64'd0);
    check("hs_sum_hold", res_sum, 64'd357);

    start_job(12, 4);
    send_line("987654321111111");
    send_line("811111111111119");
    send_line("234234234234278");
    send_line("818181911112111");
    wait_done("k12");
    check("k12_sum", res_sum, 64'd3121910778619);
    check("k12_err", 64'(err), 64'd0);
    handshake();

    // Scan latency: edges from last-digit accept to res_valid = scan cycles + ACCUM
    start_job(2, 1);
    send_line("987654321111111");
    n = 0;
    while (!res_valid && n < 1000) begin @(negedge sysclk); n++; end
`ifdef DIGIT_SEL_EARLY9_EN
    check("scan_cycles", 64'(n - 1), 64'd15);
`else
    check("scan_cycles", 64'(n - 1), 64'd28);
`endif
    check("scan_sum", res_sum, 64'd98);
    handshake();

    start_job(2, 3);
    send_line("99");
    send_line("99");
    send_line("99");
    wait_done("ovf");
    check("ovf8_sum", 64'(res_sum8), 64'd41);
    check("ovf8_flag", 64'(res_ovf8), 64'd1);
    check("ovf64_sum", res_sum, 64'd297);
    check("ovf64_flag", 64'(res_ovf), 64'd0);
    handshake();

    start_job(3, 2);
    send_line("12");
    send_line("456");
    wait_done("short");
    check("short_err", 64'(err), 64'd1);
    check("short_sum", res_sum, 64'd456);
    handshake();

    // ':' encodes digit 0xA, stored as 0
    start_job(2, 1);
    send_line("1:5");
    wait_done("bad");
    check("bad_err", 64'(err), 64'd1);
    check("bad_sum", res_sum, 64'd15);
    handshake();

    start_job(2, 0);
    wait_done("zero_lines");
    check("zero_lines_sum", res_sum, 64'd0);
    check("zero_lines_err", 64'(err), 64'd0);
    handshake();

    start_job(0, 1);
    send_line("123");
    wait_done("k0");
    check("k0_sum", res_sum, 64'd0);
    check("k0_err", 64'(err), 64'd0);
    handshake();

    // 130 digits: last two dropped; greedy picks 9 at 100 then 8 at 127
    start_job(2, 1);
    for (int i = 0; i < 130; i++)
      push((i == 100) ? 4'd9 : ((i == 127) ? 4'd8 : 4'd1), (i == 129));
    wait_done("long");
    check("long_err", 64'(err), 64'd1);
    check("long_sum", res_sum, 64'd98);
    handshake();

    // Reset during SCAN
    start_job(12, 1);
    send_line("987654321111111");
    repeat (3) @(negedge sysclk);
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge sysclk);
    check("mrst_valid", 64'(res_valid), 64'd0);
    check("mrst_sum", res_sum, 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd0);
    check("mrst_cfg_ready", 64'(cfg_ready), 64'd0);
    reset = 1'b0;
    @(negedge sysclk);
    start_job(2, 1);
    send_line("811111111111119");
    wait_done("after_rst");
    check("after_rst_sum", res_sum, 64'd89);
    check("after_rst_err", 64'(err), 64'd0);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
